stack_ctrl: RTL and testbench

//  Sequences stack traffic for the SRP16 core. Owns the stack pointer and executes PUSH/POP/CALL/RET

---
 rtl/stack_if.sv | 38 +++
 rtl/stack_ctrl.sv | 140 ++++++++++++++
 tb/tb_stack_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_if.sv
// stack_if: bundles the command, stack-pointer, memory and response signals
// of the stack controller.
//   slave  - the stack controller. It accepts commands, owns the SP, drives the
//            memory request and produces responses.
//   master - the environment: the control unit plus the shared memory bus.
// clk and reset are not part of the bundle.
interface stack_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] cmd_pc;
  logic        sp_load;
  logic [15:0] sp_din;
  logic [15:0] sp_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        fault;
  logic [1:0]  fault_code;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_pc, sp_load, sp_din, mem_rdata, mem_ack,
    output cmd_ready, sp_out, mem_req, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_data, fault, fault_code
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_pc, sp_load, sp_din, mem_rdata, mem_ack,
    input  cmd_ready, sp_out, mem_req, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_data, fault, fault_code
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: owns the SRP16 stack pointer and turns PUSH/POP/CALL/RET
// commands into single memory transactions on a req/ack port.
// The stack grows downward: a push writes mem[SP-1] and then decrements SP,
// while a pop reads mem[SP] and then increments SP.
// Ports:
//   clk    - clock; all state updates on posedge
//   reset  - synchronous, active-high
//   bus    - stack_if.slave: command, SP load/readback, memory request and
//            response signals
// Optional build macro: STACK_GUARD_EN enables the overflow/underflow guard.
// Without it, fault and fault_code are tied to 0 and SP wraps freely.
//
// state | meaning
// IDLE  | ready for a command or an SP load
// MEM   | memory request outstanding, waiting for mem_ack
// RESP  | one-cycle rsp_valid pulse
module stack_ctrl #(
  parameter logic [15:0] SP_RESET    = 16'h0000,
  parameter int          STACK_DEPTH = 256
) (
  input  logic   clk,
  input  logic   reset,
  stack_if.slave bus
);

  if (STACK_DEPTH < 1 || STACK_DEPTH > 65536) begin : g_bad_depth
    $error("stack_ctrl: STACK_DEPTH out of range");
  end

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t      state;
  logic [15:0] sp;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] rsp_data_q;
  logic [15:0] rsp_hold;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        rsp_valid_q;
  logic        is_write;

  // PUSH (00) and CALL (10) write the stack; POP (01) and RET (11) read it.
  assign is_write = ~bus.cmd_op[0];

`ifdef STACK_GUARD_EN
  logic [15:0] occupancy;
  logic        full;
  logic        empty;
  logic        fault_q;
  logic [1:0]  fault_code_q;

  // A loaded SP outside the stack range gives a large occupancy, so it is
  // seen as full and never as empty.
  assign occupancy = SP_RESET - sp;
  assign full      = int'({16'h0000, occupancy}) >= STACK_DEPTH;
  assign empty     = (sp == SP_RESET);

  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
`else
  assign bus.fault      = 1'b0;
  assign bus.fault_code = 2'b00;
`endif

  assign bus.cmd_ready = (state == IDLE) && !bus.sp_load;
  assign bus.sp_out    = sp;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sp           <= SP_RESET;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 16'h0000;
      rsp_hold     <= 16'h0000;
`ifdef STACK_GUARD_EN
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.sp_load) begin
            sp <= bus.sp_din;
          end else if (bus.cmd_valid) begin
`ifdef STACK_GUARD_EN
            if ((is_write && full) || (!is_write && empty)) begin
              // Rejected: no memory traffic, SP untouched.
              rsp_valid_q  <= 1'b1;
              rsp_data_q   <= 16'h0000;
              fault_q      <= 1'b1;
              fault_code_q <= is_write ? 2'b01 : 2'b10;
              state        <= RESP;
            end else
`endif
            begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_write;
              mem_addr_q  <= is_write ? sp - 16'd1 : sp;
              mem_wdata_q <= is_write ? (bus.cmd_op[1] ? bus.cmd_pc : bus.cmd_data) : 16'h0000;
              // PUSH echoes its data, CALL reports its target; both are cmd_data.
              rsp_hold    <= bus.cmd_data;
              state       <= MEM;
            end
          end
        end
        MEM: begin
          if (bus.mem_ack) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            sp          <= mem_we_q ? sp - 16'd1 : sp + 16'd1;
            rsp_data_q  <= mem_we_q ? rsp_hold : bus.mem_rdata;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q  <= 1'b0;
`ifdef STACK_GUARD_EN
          fault_q      <= 1'b0;
          fault_code_q <= 2'b00;
`endif
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed test of stack_ctrl with SP_RESET=0 and STACK_DEPTH=4.
// A behavioural memory acknowledges each request after a per-command delay of
// 0-3 cycles. Build with STACK_GUARD_EN defined to exercise the guard.
module tb_stack_ctrl;
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stack_if bus ();

  stack_ctrl #(.SP_RESET(16'h0000), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Memory model
  logic [15:0] mem [0:65535];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          txn_cnt   = 0;
  logic [15:0] last_addr  = 16'h0000;
  logic        last_we    = 1'b0;
  logic [15:0] last_wdata = 16'h0000;

  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        last_addr   = bus.mem_addr;
        last_we     = bus.mem_we;
        last_wdata  = bus.mem_wdata;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else            bus.mem_rdata     = mem[bus.mem_addr];
        txn_cnt++;
        wait_cnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one command, waits for its response pulse and checks the pulse is
  // a single cycle. req1 is mem_req in the cycle after acceptance.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] data, input logic [15:0] pc,
                         input int delay, output logic [15:0] rdata, output logic flt,
                         output logic [1:0] code, output logic req1);
    int n;
    ack_delay = delay;
    rdata = 16'h0; flt = 1'b0; code = 2'b00;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_pc    = pc;
    n = 0;
    #1;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("cmd_ready_timeout", {15'h0, bus.cmd_ready}, 16'h1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    req1 = bus.mem_req;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    check("rsp_timeout", {15'h0, bus.rsp_valid}, 16'h1);
    rdata = bus.rsp_data;
    flt   = bus.fault;
    code  = bus.fault_code;
    @(negedge clk);
    check("rsp_one_cycle", {15'h0, bus.rsp_valid}, 16'h0);
    check("fault_idle", {14'h0, bus.fault, bus.fault_code[0]}, 16'h0);
  endtask

  logic [15:0] rd;
  logic        flt;
  logic [1:0]  code;
  logic        req1;
  int          txn_before;
  int          rsp_seen;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 16'h0;
    bus.cmd_pc    = 16'h0;
    bus.sp_load   = 1'b0;
    bus.sp_din    = 16'h0;
    bus.mem_rdata = 16'h0;
    bus.mem_ack   = 1'b0;
    mem[16'h0000] = 16'hBEEF;

    // 1: reset state and a single PUSH
    reset_dut();
    @(negedge clk);
    check("rst_sp", bus.sp_out, 16'h0000);
    check("rst_mem_req", {15'h0, bus.mem_req}, 16'h0);
    check("rst_mem_we", {15'h0, bus.mem_we}, 16'h0);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    check("rst_rsp_valid", {15'h0, bus.rsp_valid}, 16'h0);
    check("rst_rsp_data", bus.rsp_data, 16'h0000);
    check("rst_fault", {14'h0, bus.fault, bus.fault_code[0]}, 16'h0);
    check("rst_fault_code", {14'h0, bus.fault_code}, 16'h0);
    check("rst_cmd_ready", {15'h0, bus.cmd_ready}, 16'h1);

    run_cmd(OP_PUSH, 16'h1234, 16'h0, 0, rd, flt, code, req1);
    check("t1_req_next", {15'h0, req1}, 16'h1);
    check("t1_addr", last_addr, 16'hFFFF);
    check("t1_we", {15'h0, last_we}, 16'h1);
    check("t1_wdata", last_wdata, 16'h1234);
    check("t1_sp", bus.sp_out, 16'hFFFF);
    check("t1_rsp", rd, 16'h1234);

    // 2: PUSH then POP returns the pushed word
    run_cmd(OP_PUSH, 16'hAAAA, 16'h0, 2, rd, flt, code, req1);
    check("t2_push_sp", bus.sp_out, 16'hFFFE);
    run_cmd(OP_POP, 16'h0, 16'h0, 3, rd, flt, code, req1);
    check("t2_pop_addr", last_addr, 16'hFFFE);
    check("t2_pop_we", {15'h0, last_we}, 16'h0);
    check("t2_pop_rsp", rd, 16'hAAAA);
    check("t2_pop_sp", bus.sp_out, 16'hFFFF);

    // 3: CALL pushes the return address and reports the target; RET pops it
    run_cmd(OP_CALL, 16'h0400, 16'h0123, 1, rd, flt, code, req1);
    check("t3_call_addr", last_addr, 16'hFFFE);
    check("t3_call_wdata", last_wdata, 16'h0123);
    check("t3_call_rsp", rd, 16'h0400);
    check("t3_call_sp", bus.sp_out, 16'hFFFE);
    run_cmd(OP_RET, 16'h0, 16'h0, 2, rd, flt, code, req1);
    check("t3_ret_rsp", rd, 16'h0123);
    check("t3_ret_sp", bus.sp_out, 16'hFFFF);

    // 4: full / empty boundaries
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      run_cmd(OP_PUSH, 16'h0011 * 16'(i + 1), 16'h0, i, rd, flt, code, req1);
    end
    check("t4_sp_full", bus.sp_out, 16'hFFFC);
    txn_before = txn_cnt;
    run_cmd(OP_PUSH, 16'h0055, 16'h0, 1, rd, flt, code, req1);
`ifdef STACK_GUARD_EN
    check("t4_ovf_fault", {15'h0, flt}, 16'h1);
    check("t4_ovf_code", {14'h0, code}, 16'h1);
    check("t4_ovf_rsp", rd, 16'h0000);
    check("t4_ovf_noreq", {15'h0, req1}, 16'h0);
    check("t4_ovf_txn", 16'(txn_cnt - txn_before), 16'h0);
    check("t4_ovf_sp", bus.sp_out, 16'hFFFC);
    reset_dut();
    run_cmd(OP_POP, 16'h0, 16'h0, 0, rd, flt, code, req1);
    check("t4_unf_fault", {15'h0, flt}, 16'h1);
    check("t4_unf_code", {14'h0, code}, 16'h2);
    check("t4_unf_noreq", {15'h0, req1}, 16'h0);
    check("t4_unf_sp", bus.sp_out, 16'h0000);
`else
    check("t4_nog_fault", {15'h0, flt}, 16'h0);
    check("t4_nog_addr", last_addr, 16'hFFFB);
    check("t4_nog_txn", 16'(txn_cnt - txn_before), 16'h1);
    check("t4_nog_sp", bus.sp_out, 16'hFFFB);
    reset_dut();
    run_cmd(OP_POP, 16'h0, 16'h0, 0, rd, flt, code, req1);
    check("t4_wrap_addr", last_addr, 16'h0000);
    check("t4_wrap_rsp", rd, 16'hBEEF);
    check("t4_wrap_fault", {15'h0, flt}, 16'h0);
    check("t4_wrap_sp", bus.sp_out, 16'h0001);
`endif

    // 5: sp_load blocks acceptance for one cycle, then PUSH proceeds
    reset_dut();
    ack_delay = 0;
    @(negedge clk);
    bus.sp_load   = 1'b1;
    bus.sp_din    = 16'h8000;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = 16'h5555;
    #1;
    check("t5_ready_low", {15'h0, bus.cmd_ready}, 16'h0);
    @(negedge clk);
    bus.sp_load = 1'b0;
    #1;
    check("t5_sp_loaded", bus.sp_out, 16'h8000);
    check("t5_ready_high", {15'h0, bus.cmd_ready}, 16'h1);
    check("t5_no_req_yet", {15'h0, bus.mem_req}, 16'h0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("t5_req", {15'h0, bus.mem_req}, 16'h1);
    check("t5_addr", bus.mem_addr, 16'h7FFF);
    repeat (3) @(negedge clk);
    check("t5_sp_after", bus.sp_out, 16'h7FFF);

    // 6: reset during an outstanding request abandons it
    reset_dut();
    ack_delay = 3;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = 16'h9999;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("t6_req_wait1", {15'h0, bus.mem_req}, 16'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_req_dropped", {15'h0, bus.mem_req}, 16'h0);
    check("t6_sp_reset", bus.sp_out, 16'h0000);
    reset = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    check("t6_no_rsp", 16'(rsp_seen), 16'h0);
    check("t6_sp_final", bus.sp_out, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
